// File: rtl/sfq_adder_pulse_checker.sv
// rtl/sfq_adder_pulse_checker.sv - decodes SFQ adder operand/result pulse windows and checks result words
module sfq_adder_pulse_checker #(
    parameter int WIDTH       = 2,
    parameter int LATENCY     = 3,
    parameter int ERR_W       = 8,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             GCLK_Pad,
    input  logic             rst_Pad,
    input  logic             frame_Pad,
    input  logic [WIDTH-1:0] a_Pad,
    input  logic [WIDTH-1:0] b_Pad,
    input  logic             cin_Pad,
    input  logic [WIDTH:0]   res_Pad,
    output logic [WIDTH:0]   res_word,
    output logic             res_valid,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    localparam int RW   = WIDTH + 1;
    localparam int FC_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_CHECK = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    // Sticky pulse capture for the window currently open
    logic [WIDTH-1:0] a_stk_q, a_stk_d;
    logic [WIDTH-1:0] b_stk_q, b_stk_d;
    logic             cin_stk_q, cin_stk_d;
    logic [RW-1:0]    res_stk_q, res_stk_d;

    // Expected words of the last LATENCY closes; index LATENCY-1 is the oldest
    logic [RW-1:0]    dly_q [LATENCY];
    logic [RW-1:0]    dly_d [LATENCY];

    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    state_t           state_q, state_d;

    logic [RW-1:0]    res_word_q, res_word_d;
    logic             res_valid_q, res_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;

    // Window contents include the live inputs so a pulse coincident with the frame counts
    logic [WIDTH-1:0] a_win, b_win;
    logic             cin_win;
    logic [RW-1:0]    res_win;
    logic [RW-1:0]    exp_win;

    assign a_win   = a_stk_q | a_Pad;
    assign b_win   = b_stk_q | b_Pad;
    assign cin_win = cin_stk_q | cin_Pad;
    assign res_win = res_stk_q | res_Pad;
    assign exp_win = RW'(a_win) + RW'(b_win) + RW'(cin_win);

    // Next-state: capture pulses, close windows, run fill/check/halt sequencing
    always_comb begin
        a_stk_d     = a_stk_q;
        b_stk_d     = b_stk_q;
        cin_stk_d   = cin_stk_q;
        res_stk_d   = res_stk_q;
        dly_d       = dly_q;
        fcnt_d      = fcnt_q;
        state_d     = state_q;
        res_word_d  = res_word_q;
        res_valid_d = 1'b0;
        mismatch_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
        chk_cnt_d   = chk_cnt_q;

        if (frame_Pad) begin
            a_stk_d     = '0;
            b_stk_d     = '0;
            cin_stk_d   = 1'b0;
            res_stk_d   = '0;
            res_word_d  = res_win;
            res_valid_d = 1'b1;
            dly_d[0]    = exp_win;
            for (int i = 1; i < LATENCY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
            case (state_q)
                ST_FILL: begin
                    if (fcnt_q == FC_W'(LATENCY - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    chk_cnt_d = chk_cnt_q + 1'b1;
                    if (res_win != dly_q[LATENCY-1]) begin
                        mismatch_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (STOP_ON_ERR) begin
                            state_d = ST_HALT;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            a_stk_d   = a_win;
            b_stk_d   = b_win;
            cin_stk_d = cin_win;
            res_stk_d = res_win;
        end
    end

    // State registers; reset wins over a coincident frame
    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            a_stk_q     <= '0;
            b_stk_q     <= '0;
            cin_stk_q   <= 1'b0;
            res_stk_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dly_q[i] <= '0;
            end
            fcnt_q      <= '0;
            state_q     <= ST_FILL;
            res_word_q  <= '0;
            res_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            err_cnt_q   <= '0;
            chk_cnt_q   <= '0;
        end else begin
            a_stk_q     <= a_stk_d;
            b_stk_q     <= b_stk_d;
            cin_stk_q   <= cin_stk_d;
            res_stk_q   <= res_stk_d;
            dly_q       <= dly_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            res_word_q  <= res_word_d;
            res_valid_q <= res_valid_d;
            mismatch_q  <= mismatch_d;
            err_cnt_q   <= err_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
        end
    end

    assign res_word  = res_word_q;
    assign res_valid = res_valid_q;
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_cnt_q;
    assign chk_cnt   = chk_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_sfq_adder_pulse_checker.sv
// tb/tb_sfq_adder_pulse_checker.sv - self-checking bench for sfq_adder_pulse_checker
module tb_sfq_adder_pulse_checker;

    localparam int LAT = 3;

    logic       clk;
    logic       rst;
    logic       frame;
    logic [1:0] a_in, b_in;
    logic       cin_in;
    logic [2:0] res_in;

    logic [2:0]  rw0, rw1;
    logic        rv0, rv1, mm0, mm1;
    logic [1:0]  ec0;
    logic [7:0]  ec1;
    logic [15:0] cc0, cc1;
    logic [1:0]  st0, st1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    sfq_adder_pulse_checker #(.WIDTH(2), .LATENCY(LAT), .ERR_W(2), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_dut0 (
        .GCLK_Pad(clk), .rst_Pad(rst), .frame_Pad(frame), .a_Pad(a_in), .b_Pad(b_in),
        .cin_Pad(cin_in), .res_Pad(res_in), .res_word(rw0), .res_valid(rv0), .mismatch(mm0),
        .err_cnt(ec0), .chk_cnt(cc0), .state(st0)
    );

    sfq_adder_pulse_checker #(.WIDTH(2), .LATENCY(LAT), .ERR_W(8), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_dut1 (
        .GCLK_Pad(clk), .rst_Pad(rst), .frame_Pad(frame), .a_Pad(a_in), .b_Pad(b_in),
        .cin_Pad(cin_in), .res_Pad(res_in), .res_word(rw1), .res_valid(rv1), .mismatch(mm1),
        .err_cnt(ec1), .chk_cnt(cc1), .state(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: windows as OR-accumulated words, expected sums in a queue
    int m_acc_a, m_acc_b, m_acc_c, m_acc_r;
    int exp_q[$];
    int nclose = 0;
    int m_res_word = 0;
    int m_valid = 0;
    int m_mis[2] = '{0, 0};
    int m_err[2] = '{0, 0};
    int m_chk[2] = '{0, 0};
    int m_halt[2] = '{0, 0};
    int aw, bw, cw, rwv, ew, old;

    function automatic int err_max(input int k);
        return (k == 0) ? 3 : 255;
    endfunction

    function automatic int m_state(input int k);
        if (m_halt[k] != 0) return 2;
        return (nclose >= LAT) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_acc_a = 0; m_acc_b = 0; m_acc_c = 0; m_acc_r = 0;
            exp_q.delete();
            nclose = 0; m_res_word = 0; m_valid = 0;
            for (int k = 0; k < 2; k++) begin
                m_mis[k] = 0; m_err[k] = 0; m_chk[k] = 0; m_halt[k] = 0;
            end
        end else begin
            m_valid = 0;
            m_mis[0] = 0;
            m_mis[1] = 0;
            if (frame) begin
                aw  = m_acc_a | int'(a_in);
                bw  = m_acc_b | int'(b_in);
                cw  = m_acc_c | int'(cin_in);
                rwv = m_acc_r | int'(res_in);
                ew  = aw + bw + cw;
                m_res_word = rwv;
                m_valid = 1;
                exp_q.push_back(ew);
                nclose++;
                if (exp_q.size() > LAT) begin
                    old = exp_q.pop_front();
                    for (int k = 0; k < 2; k++) begin
                        if (m_halt[k] == 0) begin
                            m_chk[k] = (m_chk[k] + 1) & 16'hFFFF;
                            if (rwv != old) begin
                                m_mis[k] = 1;
                                if (m_err[k] < err_max(k)) m_err[k]++;
                                if (k == 1) m_halt[k] = 1;
                            end
                        end
                    end
                end
                m_acc_a = 0; m_acc_b = 0; m_acc_c = 0; m_acc_r = 0;
            end else begin
                m_acc_a |= int'(a_in);
                m_acc_b |= int'(b_in);
                m_acc_c |= int'(cin_in);
                m_acc_r |= int'(res_in);
            end
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0_res_word", 32'(rw0), 32'(m_res_word));
            chk("d0_res_valid", 32'(rv0), 32'(m_valid));
            chk("d0_mismatch", 32'(mm0), 32'(m_mis[0]));
            chk("d0_err_cnt", 32'(ec0), 32'(m_err[0]));
            chk("d0_chk_cnt", 32'(cc0), 32'(m_chk[0]));
            chk("d0_state", 32'(st0), 32'(m_state(0)));
            chk("d1_res_word", 32'(rw1), 32'(m_res_word));
            chk("d1_res_valid", 32'(rv1), 32'(m_valid));
            chk("d1_mismatch", 32'(mm1), 32'(m_mis[1]));
            chk("d1_err_cnt", 32'(ec1), 32'(m_err[1]));
            chk("d1_chk_cnt", 32'(cc1), 32'(m_chk[1]));
            chk("d1_state", 32'(st1), 32'(m_state(1)));
        end
    end

    task automatic cyc(input int a, input int b, input int c, input int r, input int f);
        @(negedge clk);
        rst    = 1'b0;
        a_in   = 2'(a);
        b_in   = 2'(b);
        cin_in = 1'(c);
        res_in = 3'(r);
        frame  = 1'(f);
    endtask

    task automatic rcyc(input int a, input int f);
        @(negedge clk);
        rst    = 1'b1;
        a_in   = 2'(a);
        b_in   = 2'b0;
        cin_in = 1'b0;
        res_in = 3'b0;
        frame  = 1'(f);
    endtask

    task automatic win(input int a, input int b, input int c, input int r);
        cyc(a, b, c, r, 0);
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic empties(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; res_in = '0;
        @(posedge clk);
        chk_en = 1;
        rcyc(0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("reset_res_word", 32'(rw0), 32'd0);
        chk("reset_state", 32'(st0), 32'd0);
        chk("reset_chk_cnt", 32'(cc0), 32'd0);

        // Five back-to-back empty windows
        empties(5);
        cyc(0, 0, 0, 0, 0);
        chk("t1_chk_cnt", 32'(cc0), 32'd2);
        chk("t1_state", 32'(st0), 32'd1);
        chk("t1_res_word", 32'(rw0), 32'd0);

        // Operand window 4 checked in result window 7
        rcyc(0, 0);
        empties(3);
        win(1, 1, 0, 0);
        empties(2);
        win(0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0);
        chk("t2_res_word", 32'(rw0), 32'd2);
        chk("t2_err_cnt", 32'(ec0), 32'd0);
        chk("t2_chk_cnt", 32'(cc0), 32'd4);

        // a=2,b=1,cin=1 with a stretched and repeated a pulse
        cyc(2, 0, 0, 0, 0);
        cyc(2, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 1);
        empties(2);
        win(0, 0, 0, 4);
        cyc(0, 0, 0, 0, 0);
        chk("t3_res_word", 32'(rw0), 32'd4);
        chk("t3_err_ok", 32'(ec0), 32'd0);
        win(2, 1, 1, 0);
        empties(2);
        win(0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t3_err0", 32'(ec0), 32'd1);
        chk("t3_err1", 32'(ec1), 32'd1);
        chk("t3_halt", 32'(st1), 32'd2);

        // Result pulse coincident with frame belongs to closing window
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t4_coincident", 32'(rw0), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("t4_next_empty", 32'(rw0), 32'd0);
        chk("t5_err_frozen", 32'(ec1), 32'd1);
        chk("t5_chk_frozen", 32'(cc1), 32'd12);

        // Reset mid-window with a coincident frame
        cyc(1, 0, 0, 0, 0);
        rcyc(1, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t5_rst_state", 32'(st1), 32'd0);
        chk("t5_rst_err", 32'(ec1), 32'd0);
        chk("t5_rst_valid", 32'(rv1), 32'd0);

        // Saturation of the 2-bit error counter
        empties(3);
        for (int i = 0; i < 5; i++) win(0, 0, 0, 7);
        cyc(0, 0, 0, 0, 0);
        chk("t6_err_sat", 32'(ec0), 32'd3);
        chk("t6_chk_cnt", 32'(cc0), 32'd5);
        chk("t6_halt_err", 32'(ec1), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int av, bv, cv, rv;
            av = 0; bv = 0; cv = 0; rv = 0;
            for (int j = 0; j < 2; j++) begin
                if ($urandom_range(0, 7) == 0) av |= (1 << j);
                if ($urandom_range(0, 7) == 0) bv |= (1 << j);
            end
            if ($urandom_range(0, 7) == 0) cv = 1;
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 9) == 0) rv |= (1 << j);
            end
            if ($urandom_range(0, 299) == 0) begin
                rcyc(av, int'($urandom_range(0, 1)));
            end else begin
                cyc(av, bv, cv, rv, ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
